pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard control for a 5-stage in-order pipeline.
// Forwards EX operands from MEM/WB, detects load-use hazards, resolves
// branch/jump redirects and counts stall cycles in a saturating counter.
// Optional multi-cycle EX op support is compiled in with the macro
// HAZ_MULTICYCLE_EN. Without it, mcBusy, stallEX and flushEX stay 0.
module pipe_hazard_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int MC_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              rs1Used_ID,
    input  logic              rs2Used_ID,
    input  logic [REG_AW-1:0] rs1_EX,
    input  logic [REG_AW-1:0] rs2_EX,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              memRead_EX,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic              regWrite_MEM,
    input  logic [REG_AW-1:0] rd_WB,
    input  logic              regWrite_WB,
    input  logic [XLEN-1:0]   exResult_MEM,
    input  logic [XLEN-1:0]   wbData_WB,
    input  logic [XLEN-1:0]   regData1_EX,
    input  logic [XLEN-1:0]   regData2_EX,
    input  logic              branchTaken_EX,
    input  logic [XLEN-1:0]   branchTarget_EX,
    input  logic              jump_ID,
    input  logic [XLEN-1:0]   jumpTarget_ID,
    input  logic              mcStart_EX,
    output logic [XLEN-1:0]   exSrcA,
    output logic [XLEN-1:0]   exSrcB,
    output logic              stallIF,
    output logic              stallID,
    output logic              stallEX,
    output logic              flushIF,
    output logic              flushID,
    output logic              flushEX,
    output logic              redirectEn,
    output logic [XLEN-1:0]   redirectAddr,
    output logic              mcBusy,
    output logic [CNT_W-1:0]  stallCnt
);

    logic fwd_mem_a, fwd_wb_a, fwd_mem_b, fwd_wb_b;
    logic load_use;
    logic mc_stall;   // multi-cycle op holds the front of the pipe this cycle
    logic mc_busy;    // FSM is in the busy window (after the start cycle)

    assign fwd_mem_a = regWrite_MEM && (rd_MEM != '0) && (rd_MEM == rs1_EX);
    assign fwd_wb_a  = regWrite_WB  && (rd_WB  != '0) && (rd_WB  == rs1_EX);
    assign fwd_mem_b = regWrite_MEM && (rd_MEM != '0) && (rd_MEM == rs2_EX);
    assign fwd_wb_b  = regWrite_WB  && (rd_WB  != '0) && (rd_WB  == rs2_EX);

    assign load_use = memRead_EX && (rd_EX != '0) &&
                      ((rs1Used_ID && (rs1_ID == rd_EX)) ||
                       (rs2Used_ID && (rs2_ID == rd_EX)));

    // Operand forwarding mux: the younger MEM result beats the WB result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        exSrcA = regData1_EX;
        exSrcB = regData2_EX;
        if (fwd_mem_a)     exSrcA = exResult_MEM;
        else if (fwd_wb_a) exSrcA = wbData_WB;
        if (fwd_mem_b)     exSrcB = exResult_MEM;
        else if (fwd_wb_b) exSrcB = wbData_WB;
    end

`ifdef HAZ_MULTICYCLE_EN
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MC_BUSY = 1'b1;

    logic [0:0] state, state_nxt;
    logic [3:0] mc_cnt, mc_cnt_nxt;

    // Next-state logic. The start cycle itself is the first stall cycle, so
    // the busy window ends on the cycle whose decrement brings mc_cnt to 1,
    // giving MC_LAT-1 stall cycles in total. MC_LAT=2 needs no busy window.
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        case (state)
            IDLE: begin
                if (mcStart_EX && (MC_LAT > 2)) begin
                    state_nxt  = MC_BUSY;
                    mc_cnt_nxt = 4'(MC_LAT - 1);
                end
            end
            MC_BUSY: begin
                if (mc_cnt <= 4'd2) begin
                    state_nxt  = IDLE;
                    mc_cnt_nxt = 4'd0;
                end else begin
                    mc_cnt_nxt = mc_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                mc_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State and down-counter registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state  <= IDLE;
            mc_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    assign mc_busy  = (state == MC_BUSY);
    assign mc_stall = mc_busy || ((state == IDLE) && mcStart_EX);
`else
    logic [4:0] unused_mc;
    assign unused_mc = {mcStart_EX, 4'(MC_LAT)};
    assign mc_busy   = 1'b0;
    assign mc_stall  = 1'b0;
`endif

    assign mcBusy = mc_busy;

    // Stall / flush / redirect arbitration: branch > multi-cycle > load-use > jump.
    always_comb begin
        stallIF      = 1'b0;
        stallID      = 1'b0;
        stallEX      = 1'b0;
        flushIF      = 1'b0;
        flushID      = 1'b0;
        flushEX      = 1'b0;
        redirectEn   = 1'b0;
        redirectAddr = '0;
        if (rst) begin
            if (mc_stall) begin
                stallIF = 1'b1;
                stallID = 1'b1;
                stallEX = 1'b1;
                flushEX = 1'b1;
            end
            if (branchTaken_EX) begin
                redirectEn   = 1'b1;
                redirectAddr = branchTarget_EX;
                flushIF      = 1'b1;
                flushID      = 1'b1;
            end else if (!mc_stall) begin
                if (load_use) begin
                    stallIF = 1'b1;
                    stallID = 1'b1;
                    flushID = 1'b1;
                end else if (jump_ID) begin
                    redirectEn   = 1'b1;
                    redirectAddr = jumpTarget_ID;
                    flushIF      = 1'b1;
                end
            end
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (stallIF && (stallCnt != '1)) begin
            stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
